// File: rtl/l1d_drain_pkg.sv
// Shared types and width helpers for the L1D FIFO drain/issue stage.
// The optional watchdog is enabled by defining L1D_DRAIN_TIMEOUT_EN.
package l1d_drain_pkg;

    localparam int unsigned DRAIN_PAYLOAD_WIDTH = 64;
    localparam int unsigned DRAIN_ID_WIDTH      = 2;
    localparam int unsigned DRAIN_CNT_WIDTH     = DRAIN_ID_WIDTH + 1;

    // Request format at the default configuration.
    typedef struct packed {
        logic [DRAIN_PAYLOAD_WIDTH-1:0] payload;
        logic [DRAIN_ID_WIDTH-1:0]      id;
    } drain_req_t;

    // The outstanding count must be able to hold every ID at once.
    function automatic int unsigned cnt_width(input int unsigned id_width);
        return id_width + 1;
    endfunction

endpackage

// File: rtl/l1d_drain_id_alloc.sv
// Transaction ID tracker: pending bitmap, lowest-free-ID allocator and
// registered popcount of the pending IDs.
module l1d_drain_id_alloc
    import l1d_drain_pkg::*;
#(
    parameter int unsigned ID_WIDTH = DRAIN_ID_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_en,
    input  logic [ID_WIDTH-1:0]            set_id,
    input  logic                           clr_vld,
    input  logic [ID_WIDTH-1:0]            clr_id,
    input  logic                           rsv_vld,
    input  logic [ID_WIDTH-1:0]            rsv_id,
    output logic                           free_vld,
    output logic [ID_WIDTH-1:0]            free_id,
    output logic                           clr_hit,
    output logic [cnt_width(ID_WIDTH)-1:0] count
);

    localparam int unsigned NUM_IDS   = 2 ** ID_WIDTH;
    localparam int unsigned CNT_WIDTH = cnt_width(ID_WIDTH);

    logic [NUM_IDS-1:0] pending;
    logic [NUM_IDS-1:0] pending_nxt;
    logic [NUM_IDS-1:0] busy;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_IDS-1:0] vec);
        logic [CNT_WIDTH-1:0] sum;
        sum = '0;
        for (int i = 0; i < int'(NUM_IDS); i++) begin
            sum = sum + CNT_WIDTH'(vec[i]);
        end
        return sum;
    endfunction

    // The ID held in the issue slot is not pending yet but must not be handed out again.
    always_comb begin
        busy = pending;
        if (rsv_vld) begin
            busy[rsv_id] = 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        free_vld = 1'b0;
        free_id  = '0;
        for (int i = int'(NUM_IDS) - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_vld = 1'b1;
                free_id  = ID_WIDTH'(i);
            end
        end
    end

    assign clr_hit = clr_vld && pending[clr_id];

    // A set never collides with a clear: the set ID is the slot ID, which is never pending.
    always_comb begin
        pending_nxt = pending;
        if (clr_hit) begin
            pending_nxt[clr_id] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[set_id] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: the bitmap is reset, unlike a RAM, because each bit gates allocation and the spurious check.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= pending_nxt;
            count   <= popcount(pending_nxt);
        end
    end

endmodule

// File: rtl/l1d_fifo_drain_issue.sv
// Drain stage after the L1D request FIFO: pops, tags with a free ID, issues, tracks responses.
// Define L1D_DRAIN_TIMEOUT_EN to build the outstanding-response watchdog.
module l1d_fifo_drain_issue
    import l1d_drain_pkg::*;
#(
    parameter int unsigned PAYLOAD_WIDTH   = DRAIN_PAYLOAD_WIDTH,
    parameter int unsigned ID_WIDTH        = DRAIN_ID_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     deq_vld_i,
    input  logic [PAYLOAD_WIDTH-1:0] deq_payload_i,
    output logic                     deq_rdy_o,
    output logic                     req_vld_o,
    output logic [PAYLOAD_WIDTH-1:0] req_payload_o,
    output logic [ID_WIDTH-1:0]      req_id_o,
    input  logic                     req_rdy_i,
    input  logic                     resp_vld_i,
    input  logic [ID_WIDTH-1:0]      resp_id_i,
    output logic [ID_WIDTH:0]        outstanding_o,
    output logic                     idle_o,
    output logic                     spurious_err_o,
    output logic                     timeout_err_o
);

    localparam int unsigned CNT_WIDTH = cnt_width(ID_WIDTH);

    if ((2 ** ID_WIDTH) < MAX_OUTSTANDING || MAX_OUTSTANDING < 1) begin : g_bad_credit_cfg
        $error("MAX_OUTSTANDING must lie in 1..2**ID_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [ID_WIDTH-1:0]      id;
    } slot_t;

    slot_t                slot_q;
    logic                 slot_vld;
    logic                 deq_fire;
    logic                 req_fire;
    logic                 credit_ok;
    logic [CNT_WIDTH:0]   inflight;
    logic                 free_vld;
    logic [ID_WIDTH-1:0]  free_id;
    logic                 resp_hit;
    logic [CNT_WIDTH-1:0] pending_cnt;
    logic                 spurious_q;

    assign req_vld_o     = slot_vld;
    assign req_payload_o = slot_q.payload;
    assign req_id_o      = slot_q.id;
    assign outstanding_o = pending_cnt;
    assign idle_o        = !slot_vld && (pending_cnt == '0);

    // Credits count both the unissued slot and IDs already in flight.
    assign inflight  = {1'b0, pending_cnt} + (CNT_WIDTH + 1)'(slot_vld);
    assign credit_ok = inflight < (CNT_WIDTH + 1)'(MAX_OUTSTANDING);

    // Responses never reach this term: freed IDs become usable one cycle later.
    assign deq_rdy_o = !flush_i && (!slot_vld || req_rdy_i) && credit_ok && free_vld;
    assign deq_fire  = deq_vld_i && deq_rdy_o;
    assign req_fire  = slot_vld && req_rdy_i;

    l1d_drain_id_alloc #(
        .ID_WIDTH (ID_WIDTH)
    ) u_id_alloc (
        .clk      (clk),
        .rst      (rst),
        .set_en   (req_fire && !flush_i),
        .set_id   (slot_q.id),
        .clr_vld  (resp_vld_i),
        .clr_id   (resp_id_i),
        .rsv_vld  (slot_vld),
        .rsv_id   (slot_q.id),
        .free_vld (free_vld),
        .free_id  (free_id),
        .clr_hit  (resp_hit),
        .count    (pending_cnt)
    );

    // Flush beats a same-cycle handshake: the slot is dropped without becoming pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= 1'b0;
            slot_q   <= '0;
        end else if (deq_fire) begin
            slot_vld       <= 1'b1;
            slot_q.payload <= deq_payload_i;
            slot_q.id      <= free_id;
        end else if (flush_i || req_fire) begin
            slot_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spurious_q <= 1'b0;
        end else if (resp_vld_i && !resp_hit) begin
            spurious_q <= 1'b1;
        end
    end

    assign spurious_err_o = spurious_q;

`ifdef L1D_DRAIN_TIMEOUT_EN
    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

    logic [WD_WIDTH-1:0] wd_cnt;
    logic [WD_WIDTH-1:0] wd_nxt;
    logic                timeout_q;

    // Any legitimate response counts as progress; the counter saturates at the limit.
    always_comb begin
        wd_nxt = wd_cnt;
        if (pending_cnt == '0 || resp_hit) begin
            wd_nxt = '0;
        end else if (wd_cnt != WD_LIMIT) begin
            wd_nxt = wd_cnt + WD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt    <= wd_nxt;
            timeout_q <= timeout_q || (wd_nxt == WD_LIMIT);
        end
    end

    assign timeout_err_o = timeout_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_l1d_fifo_drain_issue.sv
// Self-checking bench for l1d_fifo_drain_issue: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the drain stage.
module tb_l1d_fifo_drain_issue;

    localparam int PW   = 64;
    localparam int IW   = 2;
    localparam int MAXO = 4;
    localparam int TO   = 8;
    localparam int NIDS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          deq_vld_i;
    logic [PW-1:0] deq_payload_i;
    logic          deq_rdy_o;
    logic          req_vld_o;
    logic [PW-1:0] req_payload_o;
    logic [IW-1:0] req_id_o;
    logic          req_rdy_i;
    logic          resp_vld_i;
    logic [IW-1:0] resp_id_i;
    logic [IW:0]   outstanding_o;
    logic          idle_o;
    logic          spurious_err_o;
    logic          timeout_err_o;

    int total = 0;
    int bad   = 0;

    // Reference model state: the issue slot, the set of pending IDs, sticky flags.
    bit          m_vld;
    logic [63:0] m_pay;
    int          m_id;
    bit          m_pend[NIDS];
    bit          m_spur;
    bit          m_to;
    int          m_wd;

    l1d_fifo_drain_issue #(
        .PAYLOAD_WIDTH   (PW),
        .ID_WIDTH        (IW),
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .deq_vld_i      (deq_vld_i),
        .deq_payload_i  (deq_payload_i),
        .deq_rdy_o      (deq_rdy_o),
        .req_vld_o      (req_vld_o),
        .req_payload_o  (req_payload_o),
        .req_id_o       (req_id_o),
        .req_rdy_i      (req_rdy_i),
        .resp_vld_i     (resp_vld_i),
        .resp_id_i      (resp_id_i),
        .outstanding_o  (outstanding_o),
        .idle_o         (idle_o),
        .spurious_err_o (spurious_err_o),
        .timeout_err_o  (timeout_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NIDS; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < NIDS; i++) begin
            if (!m_pend[i] && !(m_vld && m_id == i)) return i;
        end
        return -1;
    endfunction

    function automatic bit m_rdy(input bit fl, input bit rr);
        return !fl && (!m_vld || rr) && (m_count() + int'(m_vld) < MAXO) && (m_lowest_free() >= 0);
    endfunction

    task automatic model_reset();
        m_vld  = 0;
        m_pay  = '0;
        m_id   = 0;
        m_spur = 0;
        m_to   = 0;
        m_wd   = 0;
        for (int i = 0; i < NIDS; i++) m_pend[i] = 0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        flush_i       = 1'b0;
        deq_vld_i     = 1'b0;
        deq_payload_i = '0;
        req_rdy_i     = 1'b0;
        resp_vld_i    = 1'b0;
        resp_id_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: apply inputs, compare all outputs mid-cycle, then advance the model.
    task automatic step(input bit fl, input bit dv, input logic [63:0] dp,
                        input bit rr, input bit rv, input int rid);
        bit exp_rdy;
        bit dfire;
        bit rfire;
        bit hit;
        int fid;
        int cnt_old;
        flush_i       = fl;
        deq_vld_i     = dv;
        deq_payload_i = dp;
        req_rdy_i     = rr;
        resp_vld_i    = rv;
        resp_id_i     = IW'(rid);
        @(negedge clk);
        exp_rdy = m_rdy(fl, rr);
        check("deq_rdy", deq_rdy_o, exp_rdy);
        check("req_vld", req_vld_o, m_vld);
        check("req_payload", req_payload_o, m_pay);
        check("req_id", req_id_o, m_id);
        check("outstanding", outstanding_o, m_count());
        check("idle", idle_o, !m_vld && m_count() == 0);
        check("spurious", spurious_err_o, m_spur);
        check("timeout", timeout_err_o, m_to);

        cnt_old = m_count();
        fid     = m_lowest_free();
        dfire   = dv && exp_rdy;
        rfire   = m_vld && rr;
        hit     = rv && m_pend[rid];
        if (rv && !hit) m_spur = 1;
        if (hit) m_pend[rid] = 0;
        if (rfire && !fl) m_pend[m_id] = 1;
        if (dfire) begin
            m_vld = 1;
            m_pay = dp;
            m_id  = fid;
        end else if (fl || rfire) begin
            m_vld = 0;
        end
`ifdef L1D_DRAIN_TIMEOUT_EN
        if (cnt_old == 0 || hit) m_wd = 0;
        else if (m_wd < TO) m_wd++;
        if (m_wd == TO) m_to = 1;
`else
        cnt_old = cnt_old;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        bit fl, dv, rr, rv;
        int rid;

        // Back-to-back pops until credits run out.
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 1, 64'hA0 + 64'(i), 1, 0, 0);
        check("t1_outstanding_full", outstanding_o, 4);
        check("t1_deq_rdy_blocked", deq_rdy_o, 0);

        // Out-of-order responses free IDs 2 and 0; they are reused lowest first.
        step(0, 0, 0, 1, 1, 2);
        step(0, 0, 0, 1, 1, 0);
        check("t2_outstanding_two", outstanding_o, 2);
        step(0, 1, 64'hB0, 1, 0, 0);
        check("t2_reuse_id0", req_id_o, 0);
        step(0, 1, 64'hB1, 1, 0, 0);
        check("t2_reuse_id2", req_id_o, 2);

        // Backpressure holds the slot and blocks further pops.
        do_reset();
        step(0, 1, 64'hC0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, {$urandom, $urandom}, 0, 0, 0);
        check("t3_payload_hold", req_payload_o, 64'hC0);

        // Flush drops the slot despite req_rdy_i and the ID is reused.
        step(1, 1, 64'hD0, 1, 0, 0);
        check("t4_flush_vld", req_vld_o, 0);
        check("t4_flush_outstanding", outstanding_o, 0);
        step(0, 1, 64'hD1, 1, 0, 0);
        check("t4_id_reused", req_id_o, 0);

        // Reset mid-flight, then a late response is spurious and sticky.
        for (int i = 0; i < 3; i++) step(0, 1, 64'hE0 + 64'(i), 1, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t5_spurious_sticky", spurious_err_o, 1);
        check("t5_outstanding", outstanding_o, 0);

        // One request left unanswered for longer than the watchdog limit.
        do_reset();
        step(0, 1, 64'hF0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);
`ifdef L1D_DRAIN_TIMEOUT_EN
        check("t6_timeout", timeout_err_o, 1);
`else
        check("t6_timeout", timeout_err_o, 0);
`endif

        // Random traffic; responses only target pending IDs.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            q.delete();
            for (int i = 0; i < NIDS; i++) if (m_pend[i]) q.push_back(i);
            fl  = ($urandom_range(0, 9) == 0);
            dv  = ($urandom_range(0, 9) < 7);
            rr  = ($urandom_range(0, 9) < 6);
            rv  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            rid = rv ? q[$urandom_range(0, q.size() - 1)] : int'($urandom_range(0, NIDS - 1));
            step(fl, dv, {$urandom, $urandom}, rr, rv, rid);
        end
        check("rand_no_spurious", spurious_err_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
